decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------------------
// decode_pipe
//   Instruction buffer plus one registered RV32I decode stage. Incoming
//   {instr, pc} pairs go into a DEPTH-entry FIFO. The FIFO head is decoded
//   combinationally and captured into the output bundle register whenever
//   that register is empty or being consumed.
//
//   Optional build macro: DECODE_M_EXT_EN
//     When defined, R-type words with funct7=0000001 (M extension) decode
//     to alucodes 11..14 with regwrite set. When it is not defined, those
//     words are flagged illegal.
//
// Parameters
//   DEPTH : instruction-buffer entries (power of 2, 2..16)
//   PC_W  : width of the PC carried with each instruction
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   flush                : drop every buffered and decoded instruction
//   in_valid/in_ready    : producer handshake; in_instr, in_pc are the payload
//   out_valid/out_ready  : consumer handshake; out_* is the decoded bundle
//   out_rs1/rs2/rd/funct3: raw register and funct3 fields
//   out_imm              : assembled immediate
//   out_alucode          : ALU operation code
//   out_regwrite..out_alusrcb : datapath controls
//   out_illegal          : unrecognised encoding
//   count                : number of entries held in the FIFO
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. A valid that is not accepted keeps its payload stable until
//   it is. On the output side, out_* does not change while
//   out_valid && !out_ready.
// ---------------------------------------------------------------------------
module decode_pipe #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [2:0]               out_funct3,
  output logic [31:0]              out_imm,
  output logic [3:0]               out_alucode,
  output logic                     out_regwrite,
  output logic                     out_memread,
  output logic                     out_memwrite,
  output logic                     out_memtoreg,
  output logic                     out_jump,
  output logic                     out_jalr,
  output logic                     out_branch,
  output logic                     out_alusrca,
  output logic [1:0]               out_alusrcb,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic [3:0]      alucode;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic            illegal;
  } bundle_t;

  // ---------------- FIFO storage and pointers ----------------
  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;

  logic push;
  logic pop;

  // Full is judged on the current count only. A full FIFO therefore refuses
  // a push even in a cycle where it is also popping.
  assign in_ready = !reset && !flush && (cnt_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = !reset && !flush && (cnt_q != '0) && (!out_valid || out_ready);
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // ---------------- Decode of the FIFO head ----------------
  logic [31:0] head_instr;
  bundle_t     dec;

  assign head_instr = mem_instr[rd_ptr];

  // Base-ISA ALU code for a funct3 value. alt is instr[30]. The caller
  // masks alt where it must not apply.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'd0:    code = alt ? 4'd1 : 4'd0;   // sub / add
      3'd1:    code = 4'd6;                // sll
      3'd2:    code = 4'd9;                // slt
      3'd3:    code = 4'd10;               // sltu
      3'd4:    code = 4'd4;                // xor
      3'd5:    code = alt ? 4'd8 : 4'd7;   // sra / srl
      3'd6:    code = 4'd5;                // or
      default: code = 4'd3;                // and
    endcase
    return code;
  endfunction

  always_comb begin
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_r;
    logic       is_jal;
    logic       is_jalr;

    opcode  = head_instr[6:0];
    f3      = head_instr[14:12];
    is_r    = (opcode == OP_R);
    is_jal  = (opcode == OP_JAL);
    is_jalr = (opcode == OP_JALR);

    dec          = '0;
    dec.pc       = mem_pc[rd_ptr];
    dec.rs1      = head_instr[19:15];
    dec.rs2      = head_instr[24:20];
    dec.rd       = head_instr[11:7];
    dec.funct3   = f3;
    dec.alusrca  = is_jal || is_jalr || (opcode == OP_AUIPC);
    dec.alusrcb  = {is_jal || is_jalr, !(is_r || is_jal || is_jalr)};

    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        if (head_instr[31:25] == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          case (f3)
            3'd0:               dec.alucode = 4'd11;  // mul
            3'd1, 3'd2, 3'd3:   dec.alucode = 4'd12;  // mulh*
            3'd4, 3'd5:         dec.alucode = 4'd13;  // div/divu
            default:            dec.alucode = 4'd14;  // rem/remu
          endcase
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.alucode = alu_from_f3(f3, head_instr[30]);
        end
      end
      OP_I: begin
        dec.regwrite = 1'b1;
        // instr[30] only distinguishes srai from srli. For addi it belongs
        // to the immediate.
        dec.alucode  = alu_from_f3(f3, (f3 == 3'd5) && head_instr[30]);
        if (f3 == 3'd1 || f3 == 3'd5)
          dec.imm = {27'd0, head_instr[24:20]};
        else
          dec.imm = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.imm      = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.imm      = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.imm    = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                      head_instr[30:25], head_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.imm      = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                        head_instr[20], head_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.jalr     = 1'b1;
        dec.imm      = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alucode  = 4'd2;
        dec.imm      = {head_instr[31:12], 12'h000};
      end
      OP_AUIPC: begin
        dec.regwrite = 1'b1;
        dec.imm      = {head_instr[31:12], 12'h000};
      end
      default: dec.illegal = 1'b1;
    endcase

    // An illegal word must never write state or redirect the PC.
    if (dec.illegal) begin
      dec.regwrite = 1'b0;
      dec.memread  = 1'b0;
      dec.memwrite = 1'b0;
      dec.memtoreg = 1'b0;
      dec.jump     = 1'b0;
      dec.branch   = 1'b0;
    end
  end

  // ---------------- Pointers, count, output register ----------------
  bundle_t out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (pop) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_pc       = out_q.pc;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_funct3   = out_q.funct3;
  assign out_imm      = out_q.imm;
  assign out_alucode  = out_q.alucode;
  assign out_regwrite = out_q.regwrite;
  assign out_memread  = out_q.memread;
  assign out_memwrite = out_q.memwrite;
  assign out_memtoreg = out_q.memtoreg;
  assign out_jump     = out_q.jump;
  assign out_jalr     = out_q.jalr;
  assign out_branch   = out_q.branch;
  assign out_alusrca  = out_q.alusrca;
  assign out_alusrcb  = out_q.alusrcb;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe
//   Directed bench for decode_pipe with DEPTH=4 and PC_W=32. Expected values
//   are hand-decoded from the instruction words. The streaming phase tracks
//   order through an expected queue.
// ---------------------------------------------------------------------------
module tb_decode_pipe;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [2:0]       out_funct3;
  logic [31:0]      out_imm;
  logic [3:0]       out_alucode;
  logic             out_regwrite, out_memread, out_memwrite, out_memtoreg;
  logic             out_jump, out_jalr, out_branch, out_alusrca;
  logic [1:0]       out_alusrcb;
  logic             out_illegal;
  logic [$clog2(DEPTH):0] count;

  decode_pipe #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_alucode(out_alucode),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_jump(out_jump), .out_jalr(out_jalr),
    .out_branch(out_branch), .out_alusrca(out_alusrca), .out_alusrcb(out_alusrcb),
    .out_illegal(out_illegal), .count(count)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge. Inputs change and outputs are sampled 1 time
  // unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] idx;

    // Reset
    #1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_regwrite", 32'(out_regwrite), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,-1
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("addi_count_k", 32'(count), 32'd1);
    check("addi_valid_k", 32'(out_valid), 32'd0);
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_alucode", 32'(out_alucode), 32'd0);
    check("addi_regwrite", 32'(out_regwrite), 32'd1);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_alusrcb", 32'(out_alusrcb), 32'd1);
    check("addi_count", 32'(count), 32'd0);
    step();
    check("addi_consumed", 32'(out_valid), 32'd0);

    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h200);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_branch", 32'(out_branch), 32'd1);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_regwrite", 32'(out_regwrite), 32'd0);
    check("beq_alusrcb", 32'(out_alusrcb), 32'd1);
    step();

    // Back-pressure: fill the output stage plus the 4-entry FIFO
    out_ready = 1'b0;
    drive(1'b1, 32'h123452B7, 32'h300);   // lui x5,0x12345
    step();
    drive(1'b1, 32'h0020A423, 32'h304);   // sw x2,8(x1)
    step();
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_count1", 32'(count), 32'd1);
    drive(1'b1, 32'h4040D193, 32'h308);   // srai x3,x1,4
    step();
    drive(1'b1, 32'h40208233, 32'h30C);   // sub x4,x1,x2
    step();
    drive(1'b1, 32'hFFC12303, 32'h310);   // lw x6,-4(x2)
    step();
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h00000013, 32'h314);   // rejected
    step();
    check("rej_count", 32'(count), 32'd4);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_pc", out_pc, 32'h300);
    check("hold_imm", out_imm, 32'h12345000);
    check("hold_alucode", 32'(out_alucode), 32'd2);
    check("hold_rd", 32'(out_rd), 32'd5);

    // Drain three bundles
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    check("sw_pc", out_pc, 32'h304);
    check("sw_memwrite", 32'(out_memwrite), 32'd1);
    check("sw_imm", out_imm, 32'd8);
    check("sw_regwrite", 32'(out_regwrite), 32'd0);
    check("sw_count", 32'(count), 32'd3);
    step();
    check("srai_alucode", 32'(out_alucode), 32'd8);
    check("srai_imm", out_imm, 32'd4);
    check("srai_count", 32'(count), 32'd2);
    step();
    check("sub_alucode", 32'(out_alucode), 32'd1);
    check("sub_alusrcb", 32'(out_alusrcb), 32'd0);
    check("sub_count", 32'(count), 32'd1);

    // Build count=3 with out_valid=1, then flush
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h400);
    step();
    drive(1'b1, 32'h00200093, 32'h404);
    step();
    check("preflush_count", 32'(count), 32'd3);
    check("preflush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00300093, 32'h408);
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("post_flush_count", 32'(count), 32'd0);

    // lw from the drained set is gone; test lw decode fresh
    drive(1'b1, 32'hFFC12303, 32'h500);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("lw_memread", 32'(out_memread), 32'd1);
    check("lw_memtoreg", 32'(out_memtoreg), 32'd1);
    check("lw_imm", out_imm, 32'hFFFFFFFC);
    check("lw_regwrite", 32'(out_regwrite), 32'd1);
    step();

    // jalr x1,4(x2)
    drive(1'b1, 32'h004100E7, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("jalr_jump", 32'(out_jump), 32'd1);
    check("jalr_jalr", 32'(out_jalr), 32'd1);
    check("jalr_alusrca", 32'(out_alusrca), 32'd1);
    check("jalr_alusrcb", 32'(out_alusrcb), 32'd2);
    check("jalr_imm", out_imm, 32'd4);
    step();

    // mul x3,x1,x2
    drive(1'b1, 32'h022081B3, 32'h700);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
`ifdef DECODE_M_EXT_EN
    check("mul_alucode", 32'(out_alucode), 32'd11);
    check("mul_regwrite", 32'(out_regwrite), 32'd1);
    check("mul_illegal", 32'(out_illegal), 32'd0);
`else
    check("mul_illegal", 32'(out_illegal), 32'd1);
    check("mul_regwrite", 32'(out_regwrite), 32'd0);
`endif
    step();

    // Unknown opcode
    drive(1'b1, 32'h0000007F, 32'h800);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("bad_illegal", 32'(out_illegal), 32'd1);
    check("bad_regwrite", 32'(out_regwrite), 32'd0);
    check("bad_jump", 32'(out_jump), 32'd0);
    step();

    // Streaming: 20 addi x1,x0,i through pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, {12'(i), 5'd0, 3'd0, 5'd1, 7'h13}, 32'h1000 + 32'(4 * i));
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) exp_q.push_back(32'(i));
      step();
      if (i > 0) begin
        check("stream_count", 32'(count), 32'd1);
        check("stream_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 32'd1, 32'd0);
        end else begin
          idx = exp_q.pop_front();
          check("stream_imm", out_imm, idx);
          check("stream_pc", out_pc, 32'h1000 + (idx << 2));
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_tail_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("stream_tail_missing", 32'd1, 32'd0);
    end else begin
      idx = exp_q.pop_front();
      check("stream_tail_imm", out_imm, idx);
      check("stream_tail_pc", out_pc, 32'h1000 + (idx << 2));
    end
    step();
    check("stream_end_valid", 32'(out_valid), 32'd0);
    check("stream_end_count", 32'(count), 32'd0);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
